control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have port clock, input, 1: rising-edge system clock.
REQ-003 The block SHALL have port reset, input, 1: synchronous active-high reset.
REQ-004 The block SHALL have port stop, input, 1: pause request, sampled only in T0.
REQ-005 The block SHALL have port IR, input, 32: current instruction. Opcode is IR[31:27].
REQ-006 The block SHALL have port CONFF, input, 1: branch-condition flag from the datapath.
REQ-007 The block SHALL have port clear, output, 1: datapath clear.
REQ-008 The block SHALL have port run, output, 1: high in every state except HALT.
REQ-009 The block SHALL have bus-drive outputs, 1 each: PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Csignout.
REQ-010 The block SHALL have register-load outputs, 1 each: PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin.
REQ-011 The block SHALL have register-file and memory outputs, 1 each: Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, MD_read.
REQ-012 The block SHALL have ALU-op outputs, 1 each: ADD, AND, OR, IncPC, BRANCH.

Function
REQ-013 The opcode encoding SHALL be: ld 00000, ldi 00001, st 00010, add 00011, and 00101, or 00110, addi 01100, br 10010, nop 11010, halt 11011. Every other opcode SHALL execute as nop.
REQ-014 The FSM states SHALL be RESET, T0..T7 and HALT.
REQ-015 Outputs SHALL be decoded combinationally from the state, IR opcode and CONFF. Any signal not listed for a state SHALL be 0.
REQ-016 RESET SHALL assert clear only, then go to T0.
REQ-017 T0 SHALL assert PCout, MARin, IncPC, Zlowin, then go to T1. If stop=1 in T0, all outputs SHALL be 0 and the FSM SHALL stay in T0.
REQ-018 T1 SHALL assert Zlowout, PCin, Read, MD_read, MDRin, then go to T2.
REQ-019 T2 SHALL assert MDRout, IRin, then go to T3.
REQ-020 add/and/or SHALL sequence as:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zlowin, plus ADD, AND or OR per opcode.
  - T5: Zlowout, Gra, Rin; next state T0.
REQ-021 addi SHALL sequence as:
  - T3: Grb, Rout, Yin.
  - T4: Csignout, ADD, Zlowin.
  - T5: Zlowout, Gra, Rin; next state T0.
REQ-022 ldi SHALL be identical to addi except T3 also asserts BAout, so R0 reads as zero.
REQ-023 ld SHALL sequence as:
  - T3/T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MD_read, MDRin.
  - T7: MDRout, Gra, Rin; next state T0.
REQ-024 st SHALL sequence as:
  - T3..T5: as ld.
  - T6: Gra, Rout, Write; next state T0.
REQ-025 br SHALL sequence as:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Csignout, ADD, Zlowin.
  - T6: if CONFF=1, Zlowout and PCin, else nothing; next state T0.
  - BRANCH SHALL stay 0 throughout.
REQ-026 nop SHALL spend T3 with no outputs, then go to T0.
REQ-027 halt SHALL spend T3 with no outputs, then go to HALT. HALT SHALL drive all outputs 0, including run, and leave only on reset.
REQ-028 Instruction latencies SHALL be, counted from T0 entry to the next T0: add/and/or/addi/ldi 6 cycles; ld 8; st 7; br 7; nop 4.
REQ-029 In every state at most one bus-drive output SHALL be high, counting Rout as one driver.

Reset
REQ-030 reset=1 at any clock edge, in any state and mid-instruction, SHALL force RESET on that edge. Reset SHALL take priority over stop and halt.
REQ-031 Outputs in the cycle after reset SHALL be clear=1 and run=1, with all others 0.

Structure
REQ-032 A shared package cpu_pkg SHALL hold the opcode constants and the state enumeration.
REQ-033 The block SHALL be a single module with no sub-modules: a state register plus one combinational output/next-state decoder.

Verification
REQ-034 Reset scenario: reset for 2 cycles, then release -> clear=1 for exactly one cycle; PCout, MARin, IncPC, Zlowin on the next cycle.
REQ-035 add scenario: IR=0x18918000 (add R1,R2,R3) -> T4 shows Grc, Rout, ADD, Zlowin; T5 shows Gra, Rin; back in T0 six cycles after the first T0.
REQ-036 br scenario: IR=0x92800004 run twice, with CONFF=0 then CONFF=1 -> PCin is 0 in T6, then 1 in T6.
REQ-037 Halt and stop scenario:
  - IR=0xD8000000 -> run falls after T3 and stays 0 for 20 cycles, then reset recovers to RESET.
  - stop held 5 cycles in T0 -> T0 held with all outputs 0; T1 follows release.
REQ-038 Reset during ld: reset asserted in T6 -> next state RESET. Write and Rin SHALL never pulse.
REQ-039 An assertion SHALL check REQ-029 on every cycle of all scenarios.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcode constants, the FSM state
// enumeration and a packed control word carrying every decoded output.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7,
        HALT
    } state_t;

    typedef struct packed {
        logic clear;
        logic run;
        logic pc_out;
        logic mdr_out;
        logic zlow_out;
        logic zhigh_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic csign_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic hi_in;
        logic lo_in;
        logic con_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic read;
        logic write;
        logic md_read;
        logic alu_add;
        logic alu_and;
        logic alu_or;
        logic inc_pc;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Hardwired control unit: state register plus a single combinational decoder
// producing both the next state and every control line.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CONFF,
    output logic        clear,
    output logic        run,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Csignout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        MD_read,
    output logic        ADD,
    output logic        AND,
    output logic        OR,
    output logic        IncPC,
    output logic        BRANCH
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state_q != HALT);
        state_d  = state_q;

        unique case (state_q)
            RESET: begin
                ctrl.clear = 1'b1;
                state_d    = T0;
            end
            T0: begin
                // A pause freezes fetch entirely; only run stays up.
                if (!stop) begin
                    ctrl.pc_out  = 1'b1;
                    ctrl.mar_in  = 1'b1;
                    ctrl.inc_pc  = 1'b1;
                    ctrl.zlow_in = 1'b1;
                    state_d      = T1;
                end
            end
            T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.md_read  = 1'b1;
                ctrl.mdr_in   = 1'b1;
                state_d       = T2;
            end
            T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_d      = T3;
            end
            T3: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_OR, OP_ADDI: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                        state_d    = T4;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        // BAout makes R0 read as zero for address/immediate base.
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.y_in   = 1'b1;
                        ctrl.ba_out = 1'b1;
                        state_d     = T4;
                    end
                    OP_BR: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.con_in = 1'b1;
                        state_d     = T4;
                    end
                    OP_HALT: state_d = HALT;
                    default: state_d = T0;
                endcase
            end
            T4: begin
                state_d = T5;
                case (opcode)
                    OP_ADD, OP_AND, OP_OR: begin
                        ctrl.grc     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        ctrl.alu_add = (opcode == OP_ADD);
                        ctrl.alu_and = (opcode == OP_AND);
                        ctrl.alu_or  = (opcode == OP_OR);
                    end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                        ctrl.csign_out = 1'b1;
                        ctrl.alu_add   = 1'b1;
                        ctrl.zlow_in   = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: state_d = T0;
                endcase
            end
            T5: begin
                state_d = T0;
                case (opcode)
                    OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                        state_d       = T6;
                    end
                    OP_BR: begin
                        ctrl.csign_out = 1'b1;
                        ctrl.alu_add   = 1'b1;
                        ctrl.zlow_in   = 1'b1;
                        state_d        = T6;
                    end
                    default: ;
                endcase
            end
            T6: begin
                state_d = T0;
                case (opcode)
                    OP_LD: begin
                        ctrl.read    = 1'b1;
                        ctrl.md_read = 1'b1;
                        ctrl.mdr_in  = 1'b1;
                        state_d      = T7;
                    end
                    OP_ST: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.write = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.zlow_out = CONFF;
                        ctrl.pc_in    = CONFF;
                    end
                    default: ;
                endcase
            end
            T7: begin
                state_d = T0;
                if (opcode == OP_LD) begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end
            end
            HALT: state_d = HALT;
            default: begin
                ctrl.run = 1'b0;
                state_d  = RESET;
            end
        endcase
    end

    assign clear     = ctrl.clear;
    assign run       = ctrl.run;
    assign PCout     = ctrl.pc_out;
    assign MDRout    = ctrl.mdr_out;
    assign Zlowout   = ctrl.zlow_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign InPortout = ctrl.inport_out;
    assign Csignout  = ctrl.csign_out;
    assign PCin      = ctrl.pc_in;
    assign IRin      = ctrl.ir_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign Yin       = ctrl.y_in;
    assign Zlowin    = ctrl.zlow_in;
    assign Zhighin   = ctrl.zhigh_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign CONin     = ctrl.con_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;
    assign MD_read   = ctrl.md_read;
    assign ADD       = ctrl.alu_add;
    assign AND       = ctrl.alu_and;
    assign OR        = ctrl.alu_or;
    assign IncPC     = ctrl.inc_pc;
    assign BRANCH    = ctrl.branch;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-cycle vector table of inputs and
// expected control words, plus instruction-latency sequences.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic        stop;
    logic [31:0] IR;
    logic        CONFF;
    logic clear, run, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Csignout;
    logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, MD_read;
    logic ADD, AND, OR, IncPC, BRANCH;

    control_unit dut (
        .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CONFF(CONFF),
        .clear(clear), .run(run), .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .Csignout(Csignout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
        .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .Write(Write), .MD_read(MD_read), .ADD(ADD),
        .AND(AND), .OR(OR), .IncPC(IncPC), .BRANCH(BRANCH)
    );

    localparam logic [33:0] M_CLEAR = 34'd1 << 33, M_RUN = 34'd1 << 32;
    localparam logic [33:0] M_PCOUT = 34'd1 << 31, M_MDROUT = 34'd1 << 30;
    localparam logic [33:0] M_ZLOWOUT = 34'd1 << 29, M_CSIGN = 34'd1 << 24;
    localparam logic [33:0] M_PCIN = 34'd1 << 23, M_IRIN = 34'd1 << 22;
    localparam logic [33:0] M_MARIN = 34'd1 << 21, M_MDRIN = 34'd1 << 20;
    localparam logic [33:0] M_YIN = 34'd1 << 19, M_ZLOWIN = 34'd1 << 18;
    localparam logic [33:0] M_CONIN = 34'd1 << 14, M_GRA = 34'd1 << 13;
    localparam logic [33:0] M_GRB = 34'd1 << 12, M_GRC = 34'd1 << 11;
    localparam logic [33:0] M_RIN = 34'd1 << 10, M_ROUT = 34'd1 << 9;
    localparam logic [33:0] M_BAOUT = 34'd1 << 8, M_READ = 34'd1 << 7;
    localparam logic [33:0] M_WRITE = 34'd1 << 6, M_MDREAD = 34'd1 << 5;
    localparam logic [33:0] M_ADD = 34'd1 << 4, M_AND = 34'd1 << 3;
    localparam logic [33:0] M_OR = 34'd1 << 2, M_INCPC = 34'd1 << 1;

    localparam logic [33:0] E_RST  = M_CLEAR | M_RUN;
    localparam logic [33:0] E_T0   = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
    localparam logic [33:0] E_T1   = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN;
    localparam logic [33:0] E_T2   = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [33:0] E_IDLE = M_RUN;
    localparam logic [33:0] E_ZERO = '0;

    localparam logic [31:0] IR_ADD  = 32'h18918000, IR_AND = 32'h28918000;
    localparam logic [31:0] IR_OR   = 32'h30918000, IR_ADDI = 32'h60800005;
    localparam logic [31:0] IR_LDI  = 32'h08800005, IR_LD = 32'h00800010;
    localparam logic [31:0] IR_ST   = 32'h10800010, IR_BR = 32'h92800004;
    localparam logic [31:0] IR_NOP  = 32'hD0000000, IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_UNK  = 32'hF8000000;

    typedef struct {
        string       name;
        logic        rst;
        logic        stp;
        logic [31:0] ir;
        logic        cf;
        logic [33:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_miss;

    logic [33:0] got;
    assign got = {clear, run, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout,
                  Csignout, PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin,
                  CONin, Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, MD_read, ADD, AND,
                  OR, IncPC, BRANCH};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        assert ($countones({PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout,
                            Csignout, Rout}) <= 1)
        else begin
            $display("FAIL bus_single_driver: got %b required at most one driver", got);
            n_miss++;
        end
    end

    task automatic pv(input string nm, input logic rst, input logic stp,
                      input logic [31:0] ir, input logic cf, input logic [33:0] e);
        vec_t v;
        v.name = nm; v.rst = rst; v.stp = stp; v.ir = ir; v.cf = cf; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic fetch3(input string nm, input logic [31:0] ir, input logic cf);
        pv({nm, "_T0"}, 1'b0, 1'b0, ir, cf, E_T0);
        pv({nm, "_T1"}, 1'b0, 1'b0, ir, cf, E_T1);
        pv({nm, "_T2"}, 1'b0, 1'b0, ir, cf, E_T2);
    endtask

    task automatic alu_instr(input string nm, input logic [31:0] ir, input logic [33:0] t4);
        fetch3(nm, ir, 1'b0);
        pv({nm, "_T3"}, 1'b0, 1'b0, ir, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
        pv({nm, "_T4"}, 1'b0, 1'b0, ir, 1'b0, M_RUN | t4);
        pv({nm, "_T5"}, 1'b0, 1'b0, ir, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    endtask

    task automatic mem_front(input string nm, input logic [31:0] ir);
        fetch3(nm, ir, 1'b0);
        pv({nm, "_T3"}, 1'b0, 1'b0, ir, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN | M_BAOUT);
        pv({nm, "_T4"}, 1'b0, 1'b0, ir, 1'b0, M_RUN | M_CSIGN | M_ADD | M_ZLOWIN);
    endtask

    task automatic br_instr(input string nm, input logic cf);
        fetch3(nm, IR_BR, cf);
        pv({nm, "_T3"}, 1'b0, 1'b0, IR_BR, cf, M_RUN | M_GRA | M_ROUT | M_CONIN);
        pv({nm, "_T4"}, 1'b0, 1'b0, IR_BR, cf, M_RUN | M_PCOUT | M_YIN);
        pv({nm, "_T5"}, 1'b0, 1'b0, IR_BR, cf, M_RUN | M_CSIGN | M_ADD | M_ZLOWIN);
        pv({nm, "_T6"}, 1'b0, 1'b0, IR_BR, cf, cf ? (M_RUN | M_ZLOWOUT | M_PCIN) : E_IDLE);
    endtask

    task automatic check(input string nm, input logic [33:0] actual, input logic [33:0] exp);
        n_vec++;
        if (actual !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b required %b", nm, actual, exp);
        end
    endtask

    function automatic logic fetch_seen();
        return PCout && MARin && IncPC;
    endfunction

    // Counts clock edges from one T0 to the next while the given opcode runs.
    task automatic latency(input string nm, input logic [31:0] ir, input int exp_len);
        int cnt;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fetch_seen()) found = 1'b1;
            else begin @(posedge clock); #4; end
        end
        IR = ir;
        cnt = 0;
        if (found) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(posedge clock); #4;
                cnt++;
                if (fetch_seen()) found = 1'b1;
            end
        end
        if (!found) cnt = 99;
        check(nm, 34'(cnt), 34'(exp_len));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        stop   = 1'b0;
        IR     = '0;
        CONFF  = 1'b0;

        pv("reset_hold0", 1'b1, 1'b0, '0, 1'b0, E_RST);
        pv("reset_hold1", 1'b1, 1'b0, '0, 1'b0, E_RST);
        pv("reset_release", 1'b0, 1'b0, '0, 1'b0, E_RST);
        alu_instr("add", IR_ADD, M_GRC | M_ROUT | M_ZLOWIN | M_ADD);
        alu_instr("and", IR_AND, M_GRC | M_ROUT | M_ZLOWIN | M_AND);
        fetch3("or", IR_OR, 1'b0);
        vq[vq.size() - 1].stp = 1'b1;
        pv("or_T3", 1'b0, 1'b1, IR_OR, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
        pv("or_T4", 1'b0, 1'b0, IR_OR, 1'b0, M_RUN | M_GRC | M_ROUT | M_ZLOWIN | M_OR);
        pv("or_T5", 1'b0, 1'b0, IR_OR, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        alu_instr("addi", IR_ADDI, M_CSIGN | M_ADD | M_ZLOWIN);
        mem_front("ldi", IR_LDI);
        pv("ldi_T5", 1'b0, 1'b0, IR_LDI, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        mem_front("ld", IR_LD);
        pv("ld_T5", 1'b0, 1'b0, IR_LD, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        pv("ld_T6", 1'b0, 1'b0, IR_LD, 1'b0, M_RUN | M_READ | M_MDREAD | M_MDRIN);
        pv("ld_T7", 1'b0, 1'b0, IR_LD, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN);
        mem_front("st", IR_ST);
        pv("st_T5", 1'b0, 1'b0, IR_ST, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        pv("st_T6", 1'b0, 1'b0, IR_ST, 1'b0, M_RUN | M_GRA | M_ROUT | M_WRITE);
        br_instr("br_nt", 1'b0);
        br_instr("br_tk", 1'b1);
        fetch3("nop", IR_NOP, 1'b0);
        pv("nop_T3", 1'b0, 1'b0, IR_NOP, 1'b0, E_IDLE);
        fetch3("unk", IR_UNK, 1'b0);
        pv("unk_T3", 1'b0, 1'b0, IR_UNK, 1'b0, E_IDLE);
        for (int i = 0; i < 5; i++) pv("stop_T0", 1'b0, 1'b1, IR_NOP, 1'b0, E_IDLE);
        fetch3("stop_rel", IR_NOP, 1'b0);
        pv("stop_rel_T3", 1'b0, 1'b0, IR_NOP, 1'b0, E_IDLE);
        mem_front("ld_rst", IR_LD);
        pv("ld_rst_T5", 1'b0, 1'b0, IR_LD, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        pv("ld_rst_T6", 1'b1, 1'b0, IR_LD, 1'b0, M_RUN | M_READ | M_MDREAD | M_MDRIN);
        pv("ld_rst_RESET", 1'b0, 1'b0, IR_LD, 1'b0, E_RST);
        pv("rst_over_stop_T0", 1'b1, 1'b1, IR_HALT, 1'b0, E_IDLE);
        pv("rst_over_stop_RESET", 1'b0, 1'b0, IR_HALT, 1'b0, E_RST);
        fetch3("halt", IR_HALT, 1'b0);
        pv("halt_T3", 1'b0, 1'b0, IR_HALT, 1'b0, E_IDLE);
        for (int i = 0; i < 20; i++) pv("halt_hold", 1'b0, i[0], IR_HALT, 1'b0, E_ZERO);
        pv("halt_rst", 1'b1, 1'b0, IR_HALT, 1'b0, E_ZERO);
        pv("halt_RESET", 1'b0, 1'b0, IR_NOP, 1'b0, E_RST);
        pv("halt_recover_T0", 1'b0, 1'b0, IR_NOP, 1'b0, E_T0);

        foreach (vq[i]) begin
            @(posedge clock);
            #1;
            reset = vq[i].rst;
            stop  = vq[i].stp;
            IR    = vq[i].ir;
            CONFF = vq[i].cf;
            #3;
            check(vq[i].name, got, vq[i].exp);
        end
        reset = 1'b0;
        stop  = 1'b0;
        CONFF = 1'b1;

        latency("lat_add", IR_ADD, 6);
        latency("lat_and", IR_AND, 6);
        latency("lat_or", IR_OR, 6);
        latency("lat_addi", IR_ADDI, 6);
        latency("lat_ldi", IR_LDI, 6);
        latency("lat_ld", IR_LD, 8);
        latency("lat_st", IR_ST, 7);
        latency("lat_br", IR_BR, 7);
        latency("lat_nop", IR_NOP, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
